// File: rtl/gmii_frame_gen.sv
// GMII Ethernet frame generator: emits a programmed burst of frames with
// MAC increment/wrap, optional dst chaining, swept payload lengths, IEEE
// CRC32 FCS (optionally corrupted) and a configurable inter-frame gap.
module gmii_frame_gen #(
  parameter int DATA_WIDTH  = 8,
  parameter int MIN_IFG     = 12,
  parameter int MAX_PAYLOAD = 1500,
  parameter int LEN_W       = 11,
  parameter int CNT_W       = 16
) (
  input  logic                  gmii_clk,
  input  logic                  gmii_rst,
  input  logic                  start_i,
  input  logic                  stop_i,
  input  logic [47:0]           cfg_base_dst_i,
  input  logic [47:0]           cfg_base_src_i,
  input  logic [15:0]           cfg_base_type_i,
  input  logic [CNT_W-1:0]      cfg_num_frames_i,
  input  logic [7:0]            cfg_mac_wrap_i,
  input  logic                  cfg_chain_dst_i,
  input  logic [LEN_W-1:0]      cfg_len_min_i,
  input  logic [LEN_W-1:0]      cfg_len_max_i,
  input  logic                  cfg_len_sweep_i,
  input  logic [7:0]            cfg_ifg_i,
  input  logic                  cfg_bad_fcs_i,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [CNT_W-1:0]      frame_cnt_o,
  output logic [DATA_WIDTH-1:0] gmii_tx_data_o,
  output logic                  gmii_tx_dv_o,
  output logic                  gmii_tx_er_o
);

  // Index counter must hold both payload byte positions and IFG cycles.
  localparam int IDX_W = (LEN_W > 8) ? LEN_W : 8;
  localparam logic [LEN_W-1:0] MIN_LEN = LEN_W'(46);
  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(MAX_PAYLOAD);

  // Each state names the kind of byte currently on the GMII outputs.
  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_SFD, S_HDR, S_PAY, S_FCS, S_IFG, S_FIN
  } state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              next_frame;
  logic              accept;

  logic [47:0]       base_dst_q, base_src_q;
  logic [15:0]       base_type_q;
  logic [CNT_W-1:0]  num_q;
  logic [7:0]        wrap_q, ifg_q;
  logic              chain_q, sweep_q, bad_q;
  logic [LEN_W-1:0]  len_min_q, len_max_q, len_q;
  logic [LEN_W-1:0]  clamp_min, clamp_max;
  logic [7:0]        ifg_eff;

  logic [7:0]        sel_q, prev_sel_q;
  logic [31:0]       crc_q;
  logic              stop_q;

  logic [7:0]        byte_d;
  logic              dv_d, busy_d, done_d;
  logic [47:0]       cur_dst, cur_src;
  logic [15:0]       cur_type;
  logic [111:0]      hdr, hdr_sh;
  logic [31:0]       fcs_word, fcs_sh;

  // Reflected IEEE CRC32 register update for one byte.
  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    end
    return r;
  endfunction

  assign accept       = (state_q == S_IDLE) && start_i && !done_o;
  assign gmii_tx_er_o = 1'b0;

  // Clamp the requested payload range and IFG before they are latched.
  always_comb begin
    clamp_min = cfg_len_min_i;
    if (cfg_len_min_i < MIN_LEN) clamp_min = MIN_LEN;
    else if (cfg_len_min_i > MAX_LEN) clamp_min = MAX_LEN;
    clamp_max = cfg_len_max_i;
    if (cfg_len_max_i < MIN_LEN) clamp_max = MIN_LEN;
    else if (cfg_len_max_i > MAX_LEN) clamp_max = MAX_LEN;
    if (clamp_max < clamp_min) clamp_max = clamp_min;
    ifg_eff = (cfg_ifg_i < 8'(MIN_IFG)) ? 8'(MIN_IFG) : cfg_ifg_i;
  end

  // Next-state and byte-index sequencing through the frame fields.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    next_frame = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = (cfg_num_frames_i == '0) ? S_FIN : S_PRE;
          idx_d   = '0;
        end
      end
      S_FIN: state_d = S_IDLE;
      S_PRE: begin
        if (idx_q == IDX_W'(6)) begin
          state_d = S_SFD;
          idx_d   = '0;
        end else idx_d = idx_q + IDX_W'(1);
      end
      S_SFD: begin
        state_d = S_HDR;
        idx_d   = '0;
      end
      S_HDR: begin
        if (idx_q == IDX_W'(13)) begin
          state_d = S_PAY;
          idx_d   = '0;
        end else idx_d = idx_q + IDX_W'(1);
      end
      S_PAY: begin
        if (idx_q == IDX_W'(len_q) - IDX_W'(1)) begin
          state_d = S_FCS;
          idx_d   = '0;
        end else idx_d = idx_q + IDX_W'(1);
      end
      S_FCS: begin
        if (idx_q == IDX_W'(3)) begin
          state_d = S_IFG;
          idx_d   = '0;
        end else idx_d = idx_q + IDX_W'(1);
      end
      S_IFG: begin
        if (idx_q == IDX_W'(ifg_q) - IDX_W'(1)) begin
          idx_d = '0;
          if ((frame_cnt_o < num_q) && !(stop_q || stop_i)) begin
            state_d    = S_PRE;
            next_frame = 1'b1;
          end else state_d = S_IDLE;
        end else idx_d = idx_q + IDX_W'(1);
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Build the next output byte; frame fields come from the current frame index.
  always_comb begin
    cur_src  = base_src_q + 48'(sel_q);
    cur_dst  = ((frame_cnt_o == '0) || !chain_q) ? (base_dst_q + 48'(sel_q))
                                                 : (base_src_q + 48'(prev_sel_q));
    cur_type = base_type_q + 16'(frame_cnt_o);
    hdr      = {cur_dst, cur_src, cur_type};
    hdr_sh   = hdr << {idx_d, 3'b000};
    fcs_word = ~crc_q ^ {31'd0, bad_q};
    fcs_sh   = fcs_word >> {idx_d[1:0], 3'b000};
    byte_d   = 8'h00;
    dv_d     = 1'b0;
    case (state_d)
      S_PRE: begin byte_d = 8'h55;           dv_d = 1'b1; end
      S_SFD: begin byte_d = 8'hD5;           dv_d = 1'b1; end
      S_HDR: begin byte_d = hdr_sh[111:104]; dv_d = 1'b1; end
      S_PAY: begin byte_d = idx_d[7:0];      dv_d = 1'b1; end
      S_FCS: begin byte_d = fcs_sh[7:0];     dv_d = 1'b1; end
      default: begin byte_d = 8'h00;         dv_d = 1'b0; end
    endcase
    busy_d = (state_d != S_IDLE);
    done_d = (state_q != S_IDLE) && (state_d == S_IDLE);
  end

  // State, run counters, CRC and registered GMII outputs.
  always_ff @(posedge gmii_clk) begin
    if (gmii_rst) begin
      state_q        <= S_IDLE;
      idx_q          <= '0;
      gmii_tx_data_o <= '0;
      gmii_tx_dv_o   <= 1'b0;
      busy_o         <= 1'b0;
      done_o         <= 1'b0;
      frame_cnt_o    <= '0;
      sel_q          <= '0;
      prev_sel_q     <= '0;
      len_q          <= '0;
      stop_q         <= 1'b0;
      crc_q          <= '1;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      gmii_tx_data_o <= DATA_WIDTH'(byte_d);
      gmii_tx_dv_o   <= dv_d;
      busy_o         <= busy_d;
      done_o         <= done_d;
      if (accept) begin
        frame_cnt_o <= '0;
        sel_q       <= '0;
        prev_sel_q  <= '0;
        len_q       <= clamp_min;
        stop_q      <= 1'b0;
      end else begin
        if ((state_q != S_IDLE) && stop_i) stop_q <= 1'b1;
        if ((state_d == S_FCS) && (idx_d == IDX_W'(3))) frame_cnt_o <= frame_cnt_o + CNT_W'(1);
        if (next_frame) begin
          prev_sel_q <= sel_q;
          sel_q      <= (({1'b0, sel_q} + 9'd1) >= {1'b0, wrap_q}) ? 8'd0 : sel_q + 8'd1;
          if (sweep_q) len_q <= (len_q == len_max_q) ? len_min_q : len_q + LEN_W'(1);
        end
      end
      if ((state_d == S_HDR) || (state_d == S_PAY)) crc_q <= crc32_byte(crc_q, byte_d);
      else if ((state_d == S_PRE) || (state_d == S_SFD)) crc_q <= '1;
    end
  end

  // Snapshot the burst configuration on the start accept edge.
  always_ff @(posedge gmii_clk) begin
    if (gmii_rst) begin
      base_dst_q  <= '0;
      base_src_q  <= '0;
      base_type_q <= '0;
      num_q       <= '0;
      wrap_q      <= 8'd1;
      chain_q     <= 1'b0;
      len_min_q   <= MIN_LEN;
      len_max_q   <= MIN_LEN;
      sweep_q     <= 1'b0;
      ifg_q       <= 8'(MIN_IFG);
      bad_q       <= 1'b0;
    end else if (accept) begin
      base_dst_q  <= cfg_base_dst_i;
      base_src_q  <= cfg_base_src_i;
      base_type_q <= cfg_base_type_i;
      num_q       <= cfg_num_frames_i;
      wrap_q      <= (cfg_mac_wrap_i == 8'd0) ? 8'd1 : cfg_mac_wrap_i;
      chain_q     <= cfg_chain_dst_i;
      len_min_q   <= clamp_min;
      len_max_q   <= clamp_max;
      sweep_q     <= cfg_len_sweep_i;
      ifg_q       <= ifg_eff;
      bad_q       <= cfg_bad_fcs_i;
    end
  end

endmodule
